// File: rtl/writeback_stage.sv
// writeback_stage: merges ALU results and memory-load results onto the single
// register-file write port (WE/Rd/WD) consumed by instructionDecode.
// Loads always win the port. An ALU result that loses to a load waits in a
// small in-order FIFO. Queued results drain ahead of newly offered ALU results.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en                  pipeline enable (0 = stall)
//   alu_valid/alu_ready ALU result handshake (alu_ready is combinational)
//   alu_rd, alu_data    ALU destination register and result
//   mem_valid           load result present; it has no ready and must be taken
//   mem_rd, mem_data    load destination register and data
//   WE, Rd, WD          registered register-file write port
//   q_count             FIFO occupancy, 0..DEPTH
//   pend                pending-destination scoreboard (only with WB_SCOREBOARD_EN)
//
// Build option: define WB_SCOREBOARD_EN to add the registered pend[15:0] output.
module writeback_stage #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DW    = 24,
   parameter int unsigned RW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [RW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          WE,
   output logic [RW-1:0] Rd,
   output logic [DW-1:0] WD,
   output logic [2:0]    q_count
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [15:0]   pend
`endif
);

   localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]    DEPTH_C = 3'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

   // Pointer increment that wraps modulo DEPTH (DEPTH need not be a power of 2).
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   logic [RW-1:0] r_q_rd   [DEPTH];
   logic [DW-1:0] r_q_data [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [2:0]    r_count;
   logic          r_we;
   logic [RW-1:0] r_rd;
   logic [DW-1:0] r_wd;

   logic          w_full;
   logic          w_empty;
   logic          w_xfer;
   logic          w_push;
   logic          w_pop;
   logic          w_sel;
   logic [RW-1:0] w_sel_rd;
   logic [DW-1:0] w_sel_data;

   assign w_full    = (r_count == DEPTH_C);
   assign w_empty   = (r_count == 3'd0);
   // A full FIFO can still accept when no load is present, because the head pops.
   assign alu_ready = en & (~w_full | ~mem_valid);
   assign w_xfer    = alu_valid & alu_ready;

   // Port arbitration: load, then FIFO head, then direct ALU result.
   always_comb begin
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_sel      = 1'b0;
      w_sel_rd   = r_q_rd[r_rd_ptr];
      w_sel_data = r_q_data[r_rd_ptr];
      if (en) begin
         if (mem_valid) begin
            w_sel      = 1'b1;
            w_sel_rd   = mem_rd;
            w_sel_data = mem_data;
            w_push     = w_xfer;
         end else if (!w_empty) begin
            w_sel  = 1'b1;
            w_pop  = 1'b1;
            w_push = w_xfer;
         end else if (w_xfer) begin
            w_sel      = 1'b1;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
         end
      end
   end

   // Write port, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_rd     <= '0;
         r_wd     <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= 3'd0;
      end else begin
         // r0 is hardwired zero: the result is consumed but never written.
         r_we <= w_sel & (w_sel_rd != '0);
         if (w_sel) begin
            r_rd <= w_sel_rd;
            r_wd <= w_sel_data;
         end
         if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      end
   end

   // FIFO storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_q_rd[r_wr_ptr]   <= alu_rd;
         r_q_data[r_wr_ptr] <= alu_data;
      end
   end

   assign WE      = r_we;
   assign Rd      = r_rd;
   assign WD      = r_wd;
   assign q_count = r_count;

`ifdef WB_SCOREBOARD_EN
   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] w_vld_next;
   logic [15:0]      r_pend;
   logic [15:0]      w_pend_next;

   function automatic logic [15:0] f_onehot(input logic [RW-1:0] r);
      logic [15:0] m;
      m = '0;
      for (int unsigned b = 1; b < 16; b++) begin
         if (r == RW'(b)) m[b] = 1'b1;
      end
      return m;
   endfunction

   // Next-cycle pending set: live FIFO entries plus the load being written.
   always_comb begin
      w_vld_next = r_vld;
      if (w_pop)  w_vld_next[r_rd_ptr] = 1'b0;
      if (w_push) w_vld_next[r_wr_ptr] = 1'b1;
      w_pend_next = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         if (w_vld_next[PW'(e)]) begin
            if (w_push && (r_wr_ptr == PW'(e))) w_pend_next = w_pend_next | f_onehot(alu_rd);
            else                                 w_pend_next = w_pend_next | f_onehot(r_q_rd[PW'(e)]);
         end
      end
      if (en && mem_valid) w_pend_next = w_pend_next | f_onehot(mem_rd);
      w_pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= '0;
         r_pend <= '0;
      end else begin
         r_vld  <= w_vld_next;
         r_pend <= w_pend_next;
      end
   end

   assign pend = r_pend;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (DEPTH=2, DW=24, RW=4).
module tb_writeback_stage;

   logic        clk;
   logic        rst;
   logic        en;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  alu_rd;
   logic [23:0] alu_data;
   logic        mem_valid;
   logic [3:0]  mem_rd;
   logic [23:0] mem_data;
   logic        WE;
   logic [3:0]  Rd;
   logic [23:0] WD;
   logic [2:0]  q_count;
`ifdef WB_SCOREBOARD_EN
   logic [15:0] pend;
`endif

   int n_total;
   int n_bad;

   writeback_stage #(.DEPTH(2), .DW(24), .RW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .WE        (WE),
      .Rd        (Rd),
      .WD        (WD),
      .q_count   (q_count)
`ifdef WB_SCOREBOARD_EN
      ,
      .pend      (pend)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_port(input string tag, input logic we, input logic [3:0] rd,
                           input logic [23:0] wd, input logic [2:0] q);
      chk({tag, ".WE"}, 32'(WE), 32'(we));
      chk({tag, ".Rd"}, 32'(Rd), 32'(rd));
      chk({tag, ".WD"}, 32'(WD), 32'(wd));
      chk({tag, ".q"},  32'(q_count), 32'(q));
   endtask

   // Advance one edge; sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [3:0] rd, input logic [23:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic set_mem(input logic v, input logic [3:0] rd, input logic [23:0] d);
      mem_valid = v;
      mem_rd    = rd;
      mem_data  = d;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1;
      en  = 1'b1;
      set_alu(1'b1, 4'd1, 24'h000011);
      set_mem(1'b0, 4'd0, 24'h0);

      // 1: reset held two cycles with an ALU result offered
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_port("rst", 1'b0, 4'd0, 24'h0, 3'd0);
      end
`ifdef WB_SCOREBOARD_EN
      chk("rst.pend", 32'(pend), 32'h0);
`endif

      // 2: direct ALU write
      rst = 1'b0;
      set_alu(1'b1, 4'd3, 24'h00ABCD);
      #1 chk("t2.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t2", 1'b1, 4'd3, 24'h00ABCD, 3'd0);
      set_alu(1'b0, 4'd0, 24'h0);

      // 3: load and ALU collide; ALU result follows one cycle later
      set_mem(1'b1, 4'd5, 24'h000100);
      set_alu(1'b1, 4'd2, 24'h000007);
      #1 chk("t3.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t3a", 1'b1, 4'd5, 24'h000100, 3'd1);
`ifdef WB_SCOREBOARD_EN
      chk("t3a.pend", 32'(pend), 32'h0024);
`endif
      set_mem(1'b0, 4'd0, 24'h0);
      set_alu(1'b0, 4'd0, 24'h0);
      tick();
      chk_port("t3b", 1'b1, 4'd2, 24'h000007, 3'd0);
      tick();
      chk("t3c.WE", 32'(WE), 32'd0);

      // 4: loads for three cycles fill the FIFO, then it drains in order
      set_mem(1'b1, 4'd6, 24'h000200);
      set_alu(1'b1, 4'd7, 24'h000011);
      #1 chk("t4a.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t4a", 1'b1, 4'd6, 24'h000200, 3'd1);
      set_mem(1'b1, 4'd8, 24'h000201);
      set_alu(1'b1, 4'd9, 24'h000022);
      #1 chk("t4b.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t4b", 1'b1, 4'd8, 24'h000201, 3'd2);
      set_mem(1'b1, 4'd10, 24'h000202);
      set_alu(1'b1, 4'd11, 24'h000033);
      #1 chk("t4c.ready", 32'(alu_ready), 32'd0);
      tick();
      chk_port("t4c", 1'b1, 4'd10, 24'h000202, 3'd2);
`ifdef WB_SCOREBOARD_EN
      chk("t4c.pend", 32'(pend), 32'h0680);
`endif
      set_mem(1'b0, 4'd0, 24'h0);
      #1 chk("t4d.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t4d", 1'b1, 4'd7, 24'h000011, 3'd2);
      set_alu(1'b0, 4'd0, 24'h0);
      tick();
      chk_port("t4e", 1'b1, 4'd9, 24'h000022, 3'd1);
      tick();
      chk_port("t4f", 1'b1, 4'd11, 24'h000033, 3'd0);
      tick();
      chk("t4g.WE", 32'(WE), 32'd0);

      // 5: result to r0 is consumed but not written
      set_alu(1'b1, 4'd0, 24'hFFFFFF);
      #1 chk("t5.ready", 32'(alu_ready), 32'd1);
      tick();
      chk_port("t5", 1'b0, 4'd0, 24'hFFFFFF, 3'd0);
`ifdef WB_SCOREBOARD_EN
      chk("t5.pend0", 32'(pend[0]), 32'd0);
`endif

      // 6: one queued entry, stall three cycles, then reset discards it
      set_mem(1'b1, 4'd4, 24'h000044);
      set_alu(1'b1, 4'd12, 24'h000055);
      tick();
      chk_port("t6a", 1'b1, 4'd4, 24'h000044, 3'd1);
      en = 1'b0;
      #1 chk("t6.ready", 32'(alu_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_port("t6stall", 1'b0, 4'd4, 24'h000044, 3'd1);
      end
      rst = 1'b1;
      tick();
      chk_port("t6rst", 1'b0, 4'd0, 24'h0, 3'd0);
      rst = 1'b0;
      en  = 1'b1;
      set_mem(1'b0, 4'd0, 24'h0);
      set_alu(1'b0, 4'd0, 24'h0);
      tick();
      chk_port("t6post", 1'b0, 4'd0, 24'h0, 3'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
